// File: rtl/qsys_master_if.sv
// Local command/response channels and Avalon-MM master port of qsys_master.
// The master modport is the view taken by qsys_master itself.
interface qsys_master_if #(
  parameter int unsigned address_size = 8
) ();
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic                    cmd_write;
  logic [address_size-1:0] cmd_address;
  logic [7:0]              cmd_writedata;

  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [7:0]              rsp_readdata;
  logic                    rsp_timeout;

  logic [address_size-1:0] avm_ctrl_address;
  logic [7:0]              avm_ctrl_writedata;
  logic [7:0]              avm_ctrl_readdata;
  logic                    avm_ctrl_write;
  logic                    avm_ctrl_read;
  logic                    avm_ctrl_waitrequest;

  modport master (
    input  cmd_valid, cmd_write, cmd_address, cmd_writedata, rsp_ready,
    input  avm_ctrl_readdata, avm_ctrl_waitrequest,
    output cmd_ready, rsp_valid, rsp_readdata, rsp_timeout,
    output avm_ctrl_address, avm_ctrl_writedata, avm_ctrl_write, avm_ctrl_read
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_address, cmd_writedata, rsp_ready,
    output avm_ctrl_readdata, avm_ctrl_waitrequest,
    input  cmd_ready, rsp_valid, rsp_readdata, rsp_timeout,
    input  avm_ctrl_address, avm_ctrl_writedata, avm_ctrl_write, avm_ctrl_read
  );
endinterface

// File: rtl/qsys_master.sv
// Single-outstanding Avalon-MM master: one local command becomes one read or write
// transfer, with a waitrequest stall timeout, and yields exactly one response.
module qsys_master #(
  parameter int unsigned address_size   = 8,
  parameter int unsigned timeout_cycles = 255
) (
  input  logic          csi_MCLK_clk,
  input  logic          rsi_MRST_reset_n,
  qsys_master_if.master bus_io
);

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  localparam logic [15:0] TimeoutCount = 16'(timeout_cycles);

  state_e                  state_q, state_d;
  logic                    write_q, write_d;
  logic [address_size-1:0] addr_q, addr_d;
  logic [7:0]              wdata_q, wdata_d;
  logic [15:0]             stall_q, stall_d;
  logic [7:0]              rdata_q, rdata_d;
  logic                    timeout_q, timeout_d;

  always_comb begin
    state_d   = state_q;
    write_d   = write_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    stall_d   = stall_q;
    rdata_d   = rdata_q;
    timeout_d = timeout_q;
    unique case (state_q)
      StIdle: begin
        if (bus_io.cmd_valid) begin
          write_d = bus_io.cmd_write;
          addr_d  = bus_io.cmd_address;
          wdata_d = bus_io.cmd_writedata;
          stall_d = 16'd0;
          state_d = StIssue;
        end
      end
      StIssue: begin
        // A completing slave wins over a timeout reached in the same cycle.
        if (!bus_io.avm_ctrl_waitrequest) begin
          rdata_d   = write_q ? 8'h00 : bus_io.avm_ctrl_readdata;
          timeout_d = 1'b0;
          state_d   = StResp;
        end else if (stall_q == TimeoutCount) begin
          rdata_d   = 8'h00;
          timeout_d = 1'b1;
          state_d   = StResp;
        end else begin
          stall_d = stall_q + 16'd1;
        end
      end
      StResp: begin
        if (bus_io.rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge csi_MCLK_clk) begin
    if (!rsi_MRST_reset_n) begin
      state_q   <= StIdle;
      write_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= 8'h00;
      stall_q   <= 16'd0;
      rdata_q   <= 8'h00;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      write_q   <= write_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      stall_q   <= stall_d;
      rdata_q   <= rdata_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus_io.cmd_ready          = (state_q == StIdle);
  assign bus_io.rsp_valid          = (state_q == StResp);
  assign bus_io.rsp_readdata       = rdata_q;
  assign bus_io.rsp_timeout        = timeout_q;
  assign bus_io.avm_ctrl_address   = addr_q;
  assign bus_io.avm_ctrl_writedata = wdata_q;
  assign bus_io.avm_ctrl_write     = (state_q == StIssue) && write_q;
  assign bus_io.avm_ctrl_read      = (state_q == StIssue) && !write_q;

endmodule

// File: tb/tb_qsys_master.sv
// Self-checking bench for qsys_master (timeout_cycles = 4): directed table, random
// transactions against a transaction-level model, and reset-abort sequences.
module tb_qsys_master;

  localparam int unsigned Timeout = 4;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  qsys_master_if #(.address_size(8)) bus ();

  qsys_master #(
    .address_size  (8),
    .timeout_cycles(Timeout)
  ) dut (
    .csi_MCLK_clk    (clk),
    .rsi_MRST_reset_n(rst_n),
    .bus_io          (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [7:0]  wdata;
    int unsigned stalls;       // waitrequest-high cycles before the slave answers
    logic [7:0]  rdata;
    int unsigned delay;        // cycles rsp_ready is held low
    logic [7:0]  exp_rdata;
    logic        exp_to;
    int unsigned exp_strobes;  // cycles the strobe is high
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // The slave answers after v.stalls stalls unless the stall limit hits first.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    logic timed_out = (v.stalls > Timeout);
    r.exp_to      = timed_out;
    r.exp_strobes = (timed_out ? Timeout : v.stalls) + 1;
    r.exp_rdata   = (v.wr || timed_out) ? 8'h00 : v.rdata;
    return r;
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, " cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
    chk({tag, " rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, " avm_read"}, 32'(bus.avm_ctrl_read), 32'd0);
    chk({tag, " avm_write"}, 32'(bus.avm_ctrl_write), 32'd0);
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    check_idle({tag, " pre"});
    bus.cmd_valid            = 1'b1;
    bus.cmd_write            = v.wr;
    bus.cmd_address          = v.addr;
    bus.cmd_writedata        = v.wdata;
    bus.rsp_ready            = 1'b0;
    bus.avm_ctrl_waitrequest = 1'($urandom);
    @(negedge clk);
    // Busy-time command noise must be ignored.
    bus.cmd_write     = 1'($urandom);
    bus.cmd_address   = 8'($urandom);
    bus.cmd_writedata = 8'($urandom);
    for (int unsigned i = 0; i < v.exp_strobes; i++) begin
      chk({tag, " read strobe"}, 32'(bus.avm_ctrl_read), 32'(!v.wr));
      chk({tag, " write strobe"}, 32'(bus.avm_ctrl_write), 32'(v.wr));
      chk({tag, " address"}, 32'(bus.avm_ctrl_address), 32'(v.addr));
      chk({tag, " writedata"}, 32'(bus.avm_ctrl_writedata), 32'(v.wdata));
      chk({tag, " busy cmd_ready"}, 32'(bus.cmd_ready), 32'd0);
      chk({tag, " busy rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
      bus.avm_ctrl_waitrequest = (i < v.stalls);
      bus.avm_ctrl_readdata    = (i < v.stalls) ? 8'($urandom) : v.rdata;
      @(negedge clk);
    end
    bus.avm_ctrl_waitrequest = 1'b0;
    bus.avm_ctrl_readdata    = 8'($urandom);
    for (int unsigned d = 0; d <= v.delay; d++) begin
      chk({tag, " rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
      chk({tag, " rsp_readdata"}, 32'(bus.rsp_readdata), 32'(v.exp_rdata));
      chk({tag, " rsp_timeout"}, 32'(bus.rsp_timeout), 32'(v.exp_to));
      chk({tag, " resp strobes"}, 32'({bus.avm_ctrl_read, bus.avm_ctrl_write}), 32'd0);
      chk({tag, " resp cmd_ready"}, 32'(bus.cmd_ready), 32'd0);
      if (d == v.delay) bus.rsp_ready = 1'b1;
      @(negedge clk);
    end
    bus.rsp_ready = 1'b0;
    bus.cmd_valid = 1'b0;
  endtask

  initial begin
    vec_t v;
    //            wr    addr   wdata  stl rdata  dly exp_rd to   strobes
    tbl[0] = '{1'b1, 8'h12, 8'hA5, 0, 8'h77, 0, 8'h00, 1'b0, 1};
    tbl[1] = '{1'b0, 8'h34, 8'h00, 3, 8'h5C, 0, 8'h5C, 1'b0, 4};
    tbl[2] = '{1'b0, 8'h56, 8'h11, 9, 8'hEE, 0, 8'h00, 1'b1, 5};
    tbl[3] = '{1'b0, 8'h78, 8'h22, 4, 8'hC3, 0, 8'hC3, 1'b0, 5};
    tbl[4] = '{1'b0, 8'h9A, 8'h33, 0, 8'h3E, 5, 8'h3E, 1'b0, 1};
    tbl[5] = '{1'b1, 8'hFF, 8'h00, 4, 8'h99, 2, 8'h00, 1'b0, 5};
    tbl[6] = '{1'b1, 8'h01, 8'h7E, 6, 8'h99, 1, 8'h00, 1'b1, 5};

    rst_n                    = 1'b0;
    bus.cmd_valid            = 1'b0;
    bus.cmd_write            = 1'b0;
    bus.cmd_address          = 8'h00;
    bus.cmd_writedata        = 8'h00;
    bus.rsp_ready            = 1'b0;
    bus.avm_ctrl_readdata    = 8'h00;
    bus.avm_ctrl_waitrequest = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    chk("reset rsp_timeout", 32'(bus.rsp_timeout), 32'd0);
    chk("reset rsp_readdata", 32'(bus.rsp_readdata), 32'd0);
    chk("reset address", 32'(bus.avm_ctrl_address), 32'd0);
    chk("reset writedata", 32'(bus.avm_ctrl_writedata), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (tbl[k]) run_txn(tbl[k], $sformatf("vec%0d", k));

    for (int n = 0; n < 40; n++) begin
      v.wr     = 1'($urandom);
      v.addr   = 8'($urandom);
      v.wdata  = 8'($urandom);
      v.stalls = $urandom_range(0, 7);
      v.rdata  = 8'($urandom);
      v.delay  = $urandom_range(0, 3);
      run_txn(model(v), $sformatf("rnd%0d", n));
    end

    // Reset during a stalled read aborts it with no response.
    check_idle("rst_issue pre");
    bus.cmd_valid            = 1'b1;
    bus.cmd_write            = 1'b0;
    bus.cmd_address          = 8'h44;
    bus.avm_ctrl_waitrequest = 1'b1;
    @(negedge clk);
    chk("rst_issue read on", 32'(bus.avm_ctrl_read), 32'd1);
    @(negedge clk);
    chk("rst_issue read held", 32'(bus.avm_ctrl_read), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_issue read off", 32'(bus.avm_ctrl_read), 32'd0);
    chk("rst_issue rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_issue address", 32'(bus.avm_ctrl_address), 32'd0);
    rst_n         = 1'b1;
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    check_idle("rst_issue post");
    chk("rst_issue rsp_timeout", 32'(bus.rsp_timeout), 32'd0);

    // Reset while a response waits drops the response.
    bus.cmd_valid            = 1'b1;
    bus.cmd_address          = 8'h66;
    bus.avm_ctrl_waitrequest = 1'b0;
    bus.avm_ctrl_readdata    = 8'h99;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    chk("rst_resp rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("rst_resp readdata", 32'(bus.rsp_readdata), 32'h99);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("rst_resp post");
    chk("rst_resp readdata cleared", 32'(bus.rsp_readdata), 32'd0);

    run_txn(tbl[0], "after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
